// File: rtl/toy_dmem_responder.sv
// Data-memory responder for the RISC_TOY core: single-ported word array with a fixed-latency
// in-order read pipeline, sticky out-of-range error flag and saturating access counters.
module toy_dmem_responder #(
    parameter int unsigned BW     = 32,
    parameter int unsigned AW     = 10,
    parameter int unsigned ENTRY  = 1024,
    parameter int unsigned RD_LAT = 1
) (
    input  logic          CLK,
    input  logic          RSTN,
    input  logic          DREQ,
    input  logic          DRW,
    input  logic [29:0]   DADDR,
    input  logic [BW-1:0] DWDATA,
    input  logic          ERR_CLR,
    output logic [BW-1:0] DRDATA,
    output logic          DVALID,
    output logic          DERR,
    output logic [15:0]   RD_CNT,
    output logic [15:0]   WR_CNT
);

    logic          in_range;
    logic [AW-1:0] idx;
    logic          wr_en;
    logic          rd_issue;
    logic [BW-1:0] rd_word;

    logic [BW-1:0] mem [ENTRY];

    logic [RD_LAT-1:0] vld_q, vld_d;
    logic [BW-1:0]     dat_q [RD_LAT];
    logic [BW-1:0]     dat_d [RD_LAT];
    logic [RD_LAT-1:0] stg_v;
    logic [BW-1:0]     stg_d [RD_LAT];

    logic        derr_q, derr_d;
    logic [15:0] rd_cnt_q, rd_cnt_d;
    logic [15:0] wr_cnt_q, wr_cnt_d;

    assign in_range = (DADDR[29:AW] == '0);
    assign idx      = DADDR[AW-1:0];
    assign wr_en    = DREQ & DRW & in_range;
    assign rd_issue = DREQ & ~DRW;
    // Read-at-issue: the array is sampled at the request edge, so later writes never leak in.
    assign rd_word  = in_range ? mem[idx] : '0;

    always_ff @(posedge CLK) begin
        if (wr_en) begin
            mem[idx] <= DWDATA;
        end
    end

    always_comb begin
        stg_v    = '0;
        stg_v[0] = rd_issue;
        for (int unsigned k = 0; k < RD_LAT; k++) begin
            stg_d[k] = '0;
        end
        stg_d[0] = rd_word;
        for (int unsigned k = 1; k < RD_LAT; k++) begin
            stg_v[k] = vld_q[k-1];
            stg_d[k] = dat_q[k-1];
        end
        // Data stages only load with a valid beat so the last stage holds the previous read.
        vld_d = stg_v;
        for (int unsigned k = 0; k < RD_LAT; k++) begin
            dat_d[k] = stg_v[k] ? stg_d[k] : dat_q[k];
        end
    end

    always_comb begin
        derr_d = derr_q;
        if (ERR_CLR) begin
            derr_d = 1'b0;
        end
        if (DREQ && !in_range) begin
            derr_d = 1'b1;
        end

        rd_cnt_d = rd_cnt_q;
        if (DREQ && !DRW && in_range && (rd_cnt_q != 16'hFFFF)) begin
            rd_cnt_d = rd_cnt_q + 16'd1;
        end

        wr_cnt_d = wr_cnt_q;
        if (wr_en && (wr_cnt_q != 16'hFFFF)) begin
            wr_cnt_d = wr_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge CLK) begin
        if (!RSTN) begin
            vld_q <= '0;
            for (int unsigned k = 0; k < RD_LAT; k++) begin
                dat_q[k] <= '0;
            end
            derr_q   <= 1'b0;
            rd_cnt_q <= '0;
            wr_cnt_q <= '0;
        end else begin
            vld_q <= vld_d;
            for (int unsigned k = 0; k < RD_LAT; k++) begin
                dat_q[k] <= dat_d[k];
            end
            derr_q   <= derr_d;
            rd_cnt_q <= rd_cnt_d;
            wr_cnt_q <= wr_cnt_d;
        end
    end

    assign DVALID = vld_q[RD_LAT-1];
    assign DRDATA = dat_q[RD_LAT-1];
    assign DERR   = derr_q;
    assign RD_CNT = rd_cnt_q;
    assign WR_CNT = wr_cnt_q;

endmodule

// File: tb/tb_toy_dmem_responder.sv
// Directed bench for toy_dmem_responder: three instances (read latency 1, 2, 3) share one
// stimulus stream; a vector table drives the latency-1 instance, hand sequences cover the rest.
module tb_toy_dmem_responder;

    logic        CLK;
    logic        RSTN;
    logic        DREQ;
    logic        DRW;
    logic [29:0] DADDR;
    logic [31:0] DWDATA;
    logic        ERR_CLR;

    logic [31:0] drdata1, drdata2, drdata3;
    logic        dvalid1, dvalid2, dvalid3;
    logic        derr1, derr2, derr3;
    logic [15:0] rdcnt1, rdcnt2, rdcnt3;
    logic [15:0] wrcnt1, wrcnt2, wrcnt3;

    int checks = 0;
    int errors = 0;

    toy_dmem_responder #(.BW(32), .AW(10), .ENTRY(1024), .RD_LAT(1)) u1 (
        .CLK(CLK), .RSTN(RSTN), .DREQ(DREQ), .DRW(DRW), .DADDR(DADDR), .DWDATA(DWDATA),
        .ERR_CLR(ERR_CLR), .DRDATA(drdata1), .DVALID(dvalid1), .DERR(derr1),
        .RD_CNT(rdcnt1), .WR_CNT(wrcnt1)
    );
    toy_dmem_responder #(.BW(32), .AW(10), .ENTRY(1024), .RD_LAT(2)) u2 (
        .CLK(CLK), .RSTN(RSTN), .DREQ(DREQ), .DRW(DRW), .DADDR(DADDR), .DWDATA(DWDATA),
        .ERR_CLR(ERR_CLR), .DRDATA(drdata2), .DVALID(dvalid2), .DERR(derr2),
        .RD_CNT(rdcnt2), .WR_CNT(wrcnt2)
    );
    toy_dmem_responder #(.BW(32), .AW(10), .ENTRY(1024), .RD_LAT(3)) u3 (
        .CLK(CLK), .RSTN(RSTN), .DREQ(DREQ), .DRW(DRW), .DADDR(DADDR), .DWDATA(DWDATA),
        .ERR_CLR(ERR_CLR), .DRDATA(drdata3), .DVALID(dvalid3), .DERR(derr3),
        .RD_CNT(rdcnt3), .WR_CNT(wrcnt3)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        logic        dreq;
        logic        drw;
        logic [29:0] addr;
        logic [31:0] wdata;
        logic        clr;
        logic        ev;
        logic [31:0] ed;
        logic        ee;
        logic [15:0] erd;
        logic [15:0] ewr;
    } vec_t;

    vec_t vecs [18];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Drive one request between edges, then return just after the sampling edge.
    task automatic cyc(input logic rq, input logic rw, input logic [29:0] a,
                       input logic [31:0] wd, input logic cl);
        @(negedge CLK);
        DREQ    = rq;
        DRW     = rw;
        DADDR   = a;
        DWDATA  = wd;
        ERR_CLR = cl;
        @(posedge CLK);
        #1;
    endtask

    task automatic idle();
        cyc(1'b0, 1'b0, 30'h0, 32'h0, 1'b0);
    endtask

    initial begin
        RSTN = 1'b0; DREQ = 1'b0; DRW = 1'b0; DADDR = '0; DWDATA = '0; ERR_CLR = 1'b0;

        //          dreq drw  addr          wdata         clr  ev   ed            ee   rd  wr
        vecs[0]  = '{1'b0, 1'b0, 30'h000,      32'h0,        1'b0, 1'b0, 32'h0,        1'b0, 0, 0};
        vecs[1]  = '{1'b1, 1'b1, 30'h010,      32'hDEADBEEF, 1'b0, 1'b0, 32'h0,        1'b0, 0, 1};
        vecs[2]  = '{1'b1, 1'b0, 30'h010,      32'h0,        1'b0, 1'b1, 32'hDEADBEEF, 1'b0, 1, 1};
        vecs[3]  = '{1'b0, 1'b0, 30'h000,      32'h0,        1'b0, 1'b0, 32'hDEADBEEF, 1'b0, 1, 1};
        vecs[4]  = '{1'b1, 1'b1, 30'h000,      32'hA5A5A5A5, 1'b0, 1'b0, 32'hDEADBEEF, 1'b0, 1, 2};
        vecs[5]  = '{1'b1, 1'b1, 30'h3FF,      32'h12345678, 1'b0, 1'b0, 32'hDEADBEEF, 1'b0, 1, 3};
        vecs[6]  = '{1'b1, 1'b0, 30'h3FF,      32'h0,        1'b0, 1'b1, 32'h12345678, 1'b0, 2, 3};
        vecs[7]  = '{1'b1, 1'b1, 30'h400,      32'hFFFFFFFF, 1'b0, 1'b0, 32'h12345678, 1'b1, 2, 3};
        vecs[8]  = '{1'b1, 1'b0, 30'h000,      32'h0,        1'b0, 1'b1, 32'hA5A5A5A5, 1'b1, 3, 3};
        vecs[9]  = '{1'b1, 1'b0, 30'h400,      32'h0,        1'b0, 1'b1, 32'h0,        1'b1, 3, 3};
        vecs[10] = '{1'b0, 1'b0, 30'h000,      32'h0,        1'b1, 1'b0, 32'h0,        1'b0, 3, 3};
        vecs[11] = '{1'b1, 1'b0, 30'h400,      32'h0,        1'b1, 1'b1, 32'h0,        1'b1, 3, 3};
        vecs[12] = '{1'b0, 1'b0, 30'h000,      32'h0,        1'b1, 1'b0, 32'h0,        1'b0, 3, 3};
        vecs[13] = '{1'b1, 1'b0, 30'h3FFFFFFF, 32'h0,        1'b0, 1'b1, 32'h0,        1'b1, 3, 3};
        vecs[14] = '{1'b0, 1'b1, 30'h010,      32'h0,        1'b0, 1'b0, 32'h0,        1'b1, 3, 3};
        vecs[15] = '{1'b1, 1'b0, 30'h010,      32'h0,        1'b0, 1'b1, 32'hDEADBEEF, 1'b1, 4, 3};
        vecs[16] = '{1'b1, 1'b0, 30'h000,      32'h0,        1'b0, 1'b1, 32'hA5A5A5A5, 1'b1, 5, 3};
        vecs[17] = '{1'b1, 1'b0, 30'h3FF,      32'h0,        1'b0, 1'b1, 32'h12345678, 1'b1, 6, 3};

        idle();
        idle();
        RSTN = 1'b1;

        // Latency-1 table: outputs after each edge reflect that edge's request.
        for (int i = 0; i < 18; i++) begin
            cyc(vecs[i].dreq, vecs[i].drw, vecs[i].addr, vecs[i].wdata, vecs[i].clr);
            chk($sformatf("v%0d dvalid", i), {31'b0, dvalid1}, {31'b0, vecs[i].ev});
            chk($sformatf("v%0d drdata", i), drdata1, vecs[i].ed);
            chk($sformatf("v%0d derr", i), {31'b0, derr1}, {31'b0, vecs[i].ee});
            chk($sformatf("v%0d rd_cnt", i), {16'b0, rdcnt1}, {16'b0, vecs[i].erd});
            chk($sformatf("v%0d wr_cnt", i), {16'b0, wrcnt1}, {16'b0, vecs[i].ewr});
        end

        // Latency 3: four back-to-back reads of preloaded 0..3.
        for (int i = 0; i < 4; i++) cyc(1'b1, 1'b1, 30'(i), 32'(i), 1'b0);
        idle();
        idle();
        cyc(1'b1, 1'b0, 30'h0, 32'h0, 1'b0);
        chk("l3 burst e0 dvalid", {31'b0, dvalid3}, 32'd0);
        cyc(1'b1, 1'b0, 30'h1, 32'h0, 1'b0);
        chk("l3 burst e1 dvalid", {31'b0, dvalid3}, 32'd0);
        cyc(1'b1, 1'b0, 30'h2, 32'h0, 1'b0);
        chk("l3 burst e2 dvalid", {31'b0, dvalid3}, 32'd1);
        chk("l3 burst e2 data", drdata3, 32'd0);
        cyc(1'b1, 1'b0, 30'h3, 32'h0, 1'b0);
        chk("l3 burst e3 dvalid", {31'b0, dvalid3}, 32'd1);
        chk("l3 burst e3 data", drdata3, 32'd1);
        idle();
        chk("l3 burst e4 dvalid", {31'b0, dvalid3}, 32'd1);
        chk("l3 burst e4 data", drdata3, 32'd2);
        idle();
        chk("l3 burst e5 dvalid", {31'b0, dvalid3}, 32'd1);
        chk("l3 burst e5 data", drdata3, 32'd3);
        idle();
        chk("l3 burst e6 dvalid", {31'b0, dvalid3}, 32'd0);
        chk("l3 burst e6 hold", drdata3, 32'd3);

        // Latency 2: write to an address with its read in flight.
        cyc(1'b1, 1'b1, 30'h5, 32'h11, 1'b0);
        cyc(1'b1, 1'b1, 30'h8, 32'h77, 1'b0);
        idle();
        idle();
        cyc(1'b1, 1'b0, 30'h5, 32'h0, 1'b0);
        chk("l2 raw e0 dvalid", {31'b0, dvalid2}, 32'd0);
        cyc(1'b1, 1'b1, 30'h5, 32'h22, 1'b0);
        chk("l2 raw e1 dvalid", {31'b0, dvalid2}, 32'd1);
        chk("l2 raw old data", drdata2, 32'h11);
        cyc(1'b1, 1'b0, 30'h5, 32'h0, 1'b0);
        chk("l2 reread e0 dvalid", {31'b0, dvalid2}, 32'd0);
        idle();
        chk("l2 reread dvalid", {31'b0, dvalid2}, 32'd1);
        chk("l2 reread data", drdata2, 32'h22);
        idle();
        idle();

        // Latency 3: reset lands while a read is in flight.
        cyc(1'b1, 1'b0, 30'h8, 32'h0, 1'b0);
        RSTN = 1'b0;
        idle();
        chk("rst e1 dvalid", {31'b0, dvalid3}, 32'd0);
        idle();
        chk("rst e2 dvalid", {31'b0, dvalid3}, 32'd0);
        RSTN = 1'b1;
        idle();
        chk("rst e3 dvalid", {31'b0, dvalid3}, 32'd0);
        idle();
        chk("rst e4 dvalid", {31'b0, dvalid3}, 32'd0);
        chk("rst u1 outs", {drdata1, 15'b0, dvalid1, derr1, rdcnt1, wrcnt1}, '0);
        chk("rst u2 outs", {drdata2, 15'b0, dvalid2, derr2, rdcnt2, wrcnt2}, '0);
        chk("rst u3 outs", {drdata3, 15'b0, dvalid3, derr3, rdcnt3, wrcnt3}, '0);
        cyc(1'b1, 1'b0, 30'h8, 32'h0, 1'b0);
        chk("retain e0 dvalid", {31'b0, dvalid3}, 32'd0);
        idle();
        chk("retain e1 dvalid", {31'b0, dvalid3}, 32'd0);
        idle();
        chk("retain dvalid", {31'b0, dvalid3}, 32'd1);
        chk("retain data", drdata3, 32'h77);
        chk("retain rd_cnt", {16'b0, rdcnt3}, 32'd1);
        chk("retain wr_cnt", {16'b0, wrcnt3}, 32'd0);

        // Write counter saturation.
        RSTN = 1'b0;
        idle();
        RSTN = 1'b1;
        for (int i = 1; i <= 65540; i++) begin
            cyc(1'b1, 1'b1, 30'(i % 1024), 32'(i), 1'b0);
            if (i == 65534) chk("wr_cnt 65534", {16'b0, wrcnt1}, 32'h0000FFFE);
            if (i == 65535) chk("wr_cnt 65535", {16'b0, wrcnt1}, 32'h0000FFFF);
        end
        chk("wr_cnt sat", {16'b0, wrcnt1}, 32'h0000FFFF);
        chk("rd_cnt after writes", {16'b0, rdcnt1}, 32'd0);
        chk("derr after writes", {31'b0, derr1}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
